// File: rtl/bp_me_dma_arbiter.sv
// bp_me_dma_arbiter
//   Merges num_dma_p upstream bsg_cache_dma ports onto one downstream DMA port.
//   Packets are granted round-robin. A granted write locks the arbiter onto that
//   requester until all of its data beats have been forwarded. Read data is routed
//   back through an in-order FIFO of requester ids (the read-tag FIFO).
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   dma_pkt_*                 upstream packets {write_not_read, addr} + valid/yumi
//   dma_data_o/_v_o/_ready_*  read data returned to requesters (data is broadcast)
//   dma_data_i/_v_i/_yumi_o   write data from requesters
//   mem_dma_pkt_*             merged packet {write_not_read, id, addr} + valid/yumi
//   mem_dma_data_i/_v_i/_ready_and_o   downstream read data
//   mem_dma_data_o/_v_o/_yumi_i        merged write data
//
// Build option
//   BP_ME_DMA_ARB_ID_TAG_EN : when defined, the id field of mem_dma_pkt_o carries
//   the granted requester index; otherwise the id field is driven to 0.

// Flags downstream read data that arrives while no read is outstanding.
module bp_me_dma_arbiter_chk (
  input logic clk_i,
  input logic reset_i,
  input logic mem_data_v_i,
  input logic tag_empty_i
);

  // Read data must only arrive when a read tag is waiting for it.
  no_unexpected_rdata: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_data_v_i && tag_empty_i));

endmodule

module bp_me_dma_arbiter #(
  parameter int num_dma_p            = 2,
  parameter int daddr_width_p        = 28,
  parameter int fill_width_p         = 64,
  parameter int block_size_in_fill_p = 8,
  parameter int rd_tag_els_p         = 4,
  localparam int id_width_lp      = (num_dma_p > 1) ? $clog2(num_dma_p) : 1,
  localparam int pkt_width_lp     = 1 + daddr_width_p,
  localparam int mem_pkt_width_lp = 1 + id_width_lp + daddr_width_p
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,

  input  logic [num_dma_p-1:0][pkt_width_lp-1:0]    dma_pkt_i,
  input  logic [num_dma_p-1:0]                      dma_pkt_v_i,
  output logic [num_dma_p-1:0]                      dma_pkt_yumi_o,

  output logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_o,
  output logic [num_dma_p-1:0]                      dma_data_v_o,
  input  logic [num_dma_p-1:0]                      dma_data_ready_and_i,

  input  logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_i,
  input  logic [num_dma_p-1:0]                      dma_data_v_i,
  output logic [num_dma_p-1:0]                      dma_data_yumi_o,

  output logic [mem_pkt_width_lp-1:0]               mem_dma_pkt_o,
  output logic                                      mem_dma_pkt_v_o,
  input  logic                                      mem_dma_pkt_yumi_i,

  input  logic [fill_width_p-1:0]                   mem_dma_data_i,
  input  logic                                      mem_dma_data_v_i,
  output logic                                      mem_dma_data_ready_and_o,

  output logic [fill_width_p-1:0]                   mem_dma_data_o,
  output logic                                      mem_dma_data_v_o,
  input  logic                                      mem_dma_data_yumi_i
);

  localparam int cnt_width_lp     = (block_size_in_fill_p > 1) ? $clog2(block_size_in_fill_p) : 1;
  localparam int tag_ptr_width_lp = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1;
  localparam int tag_cnt_width_lp = $clog2(rd_tag_els_p + 1);

  localparam logic [cnt_width_lp-1:0]     last_beat_lp = cnt_width_lp'(block_size_in_fill_p - 1);
  localparam logic [tag_ptr_width_lp-1:0] last_tag_lp  = tag_ptr_width_lp'(rd_tag_els_p - 1);
  localparam logic [id_width_lp-1:0]      last_id_lp   = id_width_lp'(num_dma_p - 1);
  localparam logic [id_width_lp:0]        wrap_lp      = (id_width_lp+1)'(num_dma_p);

  typedef enum logic [0:0] {
    e_ready = 1'b0,
    e_write = 1'b1
  } state_e;

  state_e                      state_q,      state_d;
  logic [id_width_lp-1:0]      rr_ptr_q,     rr_ptr_d;
  logic [id_width_lp-1:0]      lock_id_q,    lock_id_d;
  logic [cnt_width_lp-1:0]     wr_cnt_q,     wr_cnt_d;
  logic [cnt_width_lp-1:0]     rd_cnt_q,     rd_cnt_d;
  logic [tag_ptr_width_lp-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
  logic [tag_ptr_width_lp-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
  logic [tag_cnt_width_lp-1:0] tag_cnt_q,    tag_cnt_d;
  logic [id_width_lp-1:0]      tag_mem_q [rd_tag_els_p];
  logic [id_width_lp-1:0]      tag_mem_d [rd_tag_els_p];

  logic [id_width_lp:0]        cand;
  logic                        grant_found;
  logic [id_width_lp-1:0]      grant_id;
  logic [id_width_lp-1:0]      rr_next;
  logic [id_width_lp-1:0]      pkt_id;
  logic [pkt_width_lp-1:0]     gnt_pkt;
  logic                        gnt_wnr;
  logic                        tag_full, tag_empty;
  logic [id_width_lp-1:0]      head_id;
  logic                        pkt_v, pkt_hs, push, pop, rd_hs, wr_hs;
  logic                        out_en;

  function automatic logic [tag_ptr_width_lp-1:0] tag_ptr_inc(input logic [tag_ptr_width_lp-1:0] p);
    return (p == last_tag_lp) ? '0 : p + tag_ptr_width_lp'(1);
  endfunction

  // Round-robin grant: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < num_dma_p; i++) begin
      cand = {1'b0, rr_ptr_q} + (id_width_lp+1)'(i);
      if (cand >= wrap_lp) begin
        cand = cand - wrap_lp;
      end else begin
        cand = cand;
      end
      if (!grant_found && dma_pkt_v_i[cand[id_width_lp-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[id_width_lp-1:0];
      end else begin
        grant_found = grant_found;
      end
    end
  end

`ifdef BP_ME_DMA_ARB_ID_TAG_EN
  assign pkt_id = grant_id;
`else
  assign pkt_id = '0;
`endif

  assign rr_next   = (grant_id == last_id_lp) ? '0 : grant_id + id_width_lp'(1);
  assign gnt_pkt   = dma_pkt_i[grant_id];
  assign gnt_wnr   = gnt_pkt[pkt_width_lp-1];
  assign tag_full  = (tag_cnt_q == tag_cnt_width_lp'(rd_tag_els_p));
  assign tag_empty = (tag_cnt_q == '0);
  assign head_id   = tag_mem_q[tag_rd_ptr_q];
  assign out_en    = ~reset_i;

  // A read grant stalls (rather than being skipped) while the tag FIFO is full,
  // so the pointer stays put until that read can issue.
  assign pkt_v  = (state_q == e_ready) & grant_found & ~(~gnt_wnr & tag_full);
  assign pkt_hs = pkt_v & mem_dma_pkt_yumi_i;
  assign push   = pkt_hs & ~gnt_wnr;
  assign rd_hs  = ~tag_empty & mem_dma_data_v_i & dma_data_ready_and_i[head_id];
  assign pop    = rd_hs & (rd_cnt_q == last_beat_lp);
  assign wr_hs  = (state_q == e_write) & mem_dma_data_yumi_i;

  // Outputs are combinational pass-through, forced to 0 while reset is held.
  assign mem_dma_pkt_v_o          = pkt_v & out_en;
  assign mem_dma_pkt_o            = {gnt_wnr, pkt_id, gnt_pkt[daddr_width_p-1:0]}
                                    & {mem_pkt_width_lp{out_en}};
  assign mem_dma_data_v_o         = (state_q == e_write) & dma_data_v_i[lock_id_q] & out_en;
  assign mem_dma_data_o           = dma_data_i[lock_id_q] & {fill_width_p{out_en}};
  assign mem_dma_data_ready_and_o = ~tag_empty & dma_data_ready_and_i[head_id] & out_en;

  // Per-requester handshakes and read-data routing by the FIFO head id.
  always_comb begin
    for (int i = 0; i < num_dma_p; i++) begin
      dma_pkt_yumi_o[i]  = pkt_hs & (grant_id == id_width_lp'(i)) & out_en;
      dma_data_yumi_o[i] = wr_hs & (lock_id_q == id_width_lp'(i)) & out_en;
      dma_data_v_o[i]    = ~tag_empty & mem_dma_data_v_i & (head_id == id_width_lp'(i)) & out_en;
      dma_data_o[i]      = mem_dma_data_i & {fill_width_p{out_en}};
    end
  end

  // Arbitration FSM next state: packet grant in e_ready, write beats in e_write.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    wr_cnt_d  = wr_cnt_q;
    case (state_q)
      e_ready: begin
        if (pkt_hs) begin
          rr_ptr_d = rr_next;
          if (gnt_wnr) begin
            state_d   = e_write;
            lock_id_d = grant_id;
            wr_cnt_d  = '0;
          end else begin
            state_d = e_ready;
          end
        end else begin
          state_d = e_ready;
        end
      end
      e_write: begin
        if (wr_hs) begin
          if (wr_cnt_q == last_beat_lp) begin
            state_d  = e_ready;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + cnt_width_lp'(1);
          end
        end else begin
          state_d = e_write;
        end
      end
      default: begin
        state_d = e_ready;
      end
    endcase
  end

  // Read-tag FIFO and read beat counter next state.
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q;
    tag_mem_d    = tag_mem_q;
    if (push) begin
      tag_mem_d[tag_wr_ptr_q] = grant_id;
      tag_wr_ptr_d            = tag_ptr_inc(tag_wr_ptr_q);
    end else begin
      tag_wr_ptr_d = tag_wr_ptr_q;
    end
    if (rd_hs) begin
      if (pop) begin
        rd_cnt_d     = '0;
        tag_rd_ptr_d = tag_ptr_inc(tag_rd_ptr_q);
      end else begin
        rd_cnt_d = rd_cnt_q + cnt_width_lp'(1);
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    case ({push, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + tag_cnt_width_lp'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - tag_cnt_width_lp'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // State registers; reset drops any in-flight transfer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= e_ready;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
      for (int i = 0; i < rd_tag_els_p; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_id_q    <= lock_id_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
      tag_mem_q    <= tag_mem_d;
    end
  end

  bp_me_dma_arbiter_chk u_chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .mem_data_v_i (mem_dma_data_v_i),
    .tag_empty_i  (tag_empty)
  );

endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// Randomized bench for bp_me_dma_arbiter with a transaction-level reference model:
// round-robin over requesters, a write lock counted in beats, and a queue of
// outstanding reads (requester id + address).
module tb_bp_me_dma_arbiter;

  localparam int NUM  = 2;
  localparam int AW   = 28;
  localparam int FW   = 64;
  localparam int BLK  = 8;
  localparam int TAGS = 4;
  localparam int IDW  = 1;
  localparam int PW   = 1 + AW;
  localparam int MPW  = 1 + IDW + AW;

  logic clk = 1'b0;
  logic reset_i;
  logic [NUM-1:0][PW-1:0] dma_pkt_i;
  logic [NUM-1:0]         dma_pkt_v_i;
  logic [NUM-1:0]         dma_pkt_yumi_o;
  logic [NUM-1:0][FW-1:0] dma_data_o;
  logic [NUM-1:0]         dma_data_v_o;
  logic [NUM-1:0]         dma_data_ready_and_i;
  logic [NUM-1:0][FW-1:0] dma_data_i;
  logic [NUM-1:0]         dma_data_v_i;
  logic [NUM-1:0]         dma_data_yumi_o;
  logic [MPW-1:0]         mem_dma_pkt_o;
  logic                   mem_dma_pkt_v_o;
  logic                   mem_dma_pkt_yumi_i;
  logic [FW-1:0]          mem_dma_data_i;
  logic                   mem_dma_data_v_i;
  logic                   mem_dma_data_ready_and_o;
  logic [FW-1:0]          mem_dma_data_o;
  logic                   mem_dma_data_v_o;
  logic                   mem_dma_data_yumi_i;

  always #5 clk = ~clk;

  bp_me_dma_arbiter #(
    .num_dma_p(NUM), .daddr_width_p(AW), .fill_width_p(FW),
    .block_size_in_fill_p(BLK), .rd_tag_els_p(TAGS)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_and_i(dma_data_ready_and_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_dma_pkt_o(mem_dma_pkt_o), .mem_dma_pkt_v_o(mem_dma_pkt_v_o),
    .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
    .mem_dma_data_i(mem_dma_data_i), .mem_dma_data_v_i(mem_dma_data_v_i),
    .mem_dma_data_ready_and_o(mem_dma_data_ready_and_o),
    .mem_dma_data_o(mem_dma_data_o), .mem_dma_data_v_o(mem_dma_data_v_o),
    .mem_dma_data_yumi_i(mem_dma_data_yumi_i)
  );

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
  } rd_t;

  // Reference model state
  rd_t rd_q[$];
  int  m_rr, m_lock, m_wr_cnt, m_rd_cnt;
  bit  m_write;
  int  wb [NUM];
  bit  drop [NUM];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] wr_word(input int i, input int b);
    return {8'hA5, 8'(i), 48'(b)};
  endfunction

  function automatic logic [FW-1:0] rd_word(input logic [AW-1:0] addr, input int b);
    return {4'hD, addr, 32'(b)};
  endfunction

  task automatic model_reset();
    rd_q.delete();
    m_rr = 0; m_lock = 0; m_wr_cnt = 0; m_rd_cnt = 0; m_write = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      drop[i] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_and_i = '0;
    dma_data_i = '0; dma_data_v_i = '0;
    mem_dma_pkt_yumi_i = 1'b0; mem_dma_data_i = '0; mem_dma_data_v_i = 1'b0;
    mem_dma_data_yumi_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_pkt_v"},     mem_dma_pkt_v_o, 64'd0);
    check_eq({tag, "_pkt"},       mem_dma_pkt_o, 64'd0);
    check_eq({tag, "_pkt_yumi"},  dma_pkt_yumi_o, 64'd0);
    check_eq({tag, "_wdata_v"},   mem_dma_data_v_o, 64'd0);
    check_eq({tag, "_wdata"},     mem_dma_data_o, 64'd0);
    check_eq({tag, "_wyumi"},     dma_data_yumi_o, 64'd0);
    check_eq({tag, "_rdata_v"},   dma_data_v_o, 64'd0);
    check_eq({tag, "_rdy"},       mem_dma_data_ready_and_o, 64'd0);
    for (int i = 0; i < NUM; i++) begin
      check_eq({tag, "_rdata"}, dma_data_o[i], 64'd0);
    end
  endtask

  // One clock of stimulus, comparison against the model and model update.
  task automatic step();
    bit found, exp_pkt_v, exp_mdv, exp_rdy, wnr;
    int g, idf;
    logic [MPW-1:0] exp_pkt;
    logic [FW-1:0]  exp_md;
    logic [NUM-1:0] exp_pyumi, exp_dyumi, exp_rv;
    @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      if (drop[i]) begin
        dma_pkt_v_i[i] = 1'b0;
        drop[i] = 1'b0;
      end
      if (!dma_pkt_v_i[i] && $urandom_range(0, 3) != 0) begin
        dma_pkt_v_i[i] = 1'b1;
        dma_pkt_i[i]   = {1'($urandom_range(0, 1)), AW'($urandom)};
      end
      dma_data_v_i[i]         = ($urandom_range(0, 3) != 0);
      dma_data_i[i]           = wr_word(i, wb[i]);
      dma_data_ready_and_i[i] = ($urandom_range(0, 3) != 0);
    end

    found = 1'b0; g = 0;
    if (!m_write) begin
      for (int k = 0; k < NUM; k++) begin
        if (!found && dma_pkt_v_i[(m_rr + k) % NUM]) begin
          found = 1'b1;
          g = (m_rr + k) % NUM;
        end
      end
    end
    wnr = dma_pkt_i[g][PW-1];
`ifdef BP_ME_DMA_ARB_ID_TAG_EN
    idf = g;
`else
    idf = 0;
`endif
    exp_pkt_v = found && !(!wnr && rd_q.size() == TAGS);
    exp_pkt   = {wnr, IDW'(idf), dma_pkt_i[g][AW-1:0]};
    mem_dma_pkt_yumi_i = exp_pkt_v && ($urandom_range(0, 2) != 0);

    exp_mdv = m_write && dma_data_v_i[m_lock];
    exp_md  = wr_word(m_lock, wb[m_lock]);
    mem_dma_data_yumi_i = exp_mdv && ($urandom_range(0, 2) != 0);

    mem_dma_data_v_i = (rd_q.size() > 0) && ($urandom_range(0, 3) != 0);
    mem_dma_data_i   = (rd_q.size() > 0) ? rd_word(rd_q[0].addr, m_rd_cnt) : {$urandom, $urandom};
    exp_rdy = (rd_q.size() > 0) && dma_data_ready_and_i[rd_q[0].id];
    exp_rv  = '0;
    if (rd_q.size() > 0) exp_rv[rd_q[0].id] = mem_dma_data_v_i;
    exp_pyumi = '0;
    if (exp_pkt_v && mem_dma_pkt_yumi_i) exp_pyumi[g] = 1'b1;
    exp_dyumi = '0;
    if (m_write) exp_dyumi[m_lock] = mem_dma_data_yumi_i;

    #1;
    check_eq("pkt_v", mem_dma_pkt_v_o, exp_pkt_v);
    if (exp_pkt_v) check_eq("pkt", mem_dma_pkt_o, exp_pkt);
    check_eq("pkt_yumi", dma_pkt_yumi_o, exp_pyumi);
    check_eq("wdata_v", mem_dma_data_v_o, exp_mdv);
    if (exp_mdv) check_eq("wdata", mem_dma_data_o, exp_md);
    check_eq("wdata_yumi", dma_data_yumi_o, exp_dyumi);
    check_eq("rdata_v", dma_data_v_o, exp_rv);
    check_eq("rdata_ready", mem_dma_data_ready_and_o, exp_rdy);
    for (int i = 0; i < NUM; i++) begin
      if (exp_rv[i] && dma_data_ready_and_i[i])
        check_eq("rdata", dma_data_o[i], rd_word(rd_q[0].addr, m_rd_cnt));
    end

    if (rd_q.size() > 0 && mem_dma_data_v_i && exp_rdy) begin
      m_rd_cnt++;
      if (m_rd_cnt == BLK) begin
        void'(rd_q.pop_front());
        m_rd_cnt = 0;
      end
    end
    if (m_write && mem_dma_data_yumi_i) begin
      wb[m_lock]++;
      m_wr_cnt++;
      if (m_wr_cnt == BLK) m_write = 1'b0;
    end else if (!m_write && exp_pkt_v && mem_dma_pkt_yumi_i) begin
      m_rr = (g + 1) % NUM;
      drop[g] = 1'b1;
      if (wnr) begin
        m_write = 1'b1; m_lock = g; m_wr_cnt = 0;
      end else begin
        rd_q.push_back('{g, dma_pkt_i[g][AW-1:0]});
      end
    end
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < NUM; i++) wb[i] = 0;
    clear_inputs();
    reset_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset_i = 1'b0;

    repeat (1500) step();

    // Drive traffic until a write has three beats done, then reset mid-transfer.
    reached = 1'b0;
    for (int n = 0; n < 3000 && !reached; n++) begin
      step();
      if (m_write && m_wr_cnt == 3) reached = 1'b1;
    end
    check_eq("reach_write_beat3", reached, 1'b1);
    if (reached) begin
      @(negedge clk);
      reset_i = 1'b1;
      #1;
      check_zero("async_reset");
      repeat (2) @(negedge clk);
      #1;
      check_zero("reset_hold");
      clear_inputs();
      model_reset();
      @(negedge clk);
      reset_i = 1'b0;
    end

    repeat (1500) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
